// File: rtl/platform_scheduler_pkg.sv
// Shared constants, FSM state type and the random-X helper for the platform scheduler.
package platform_scheduler_pkg;

    localparam int NUM_PLAT    = 16;
    localparam int IDX_W       = $clog2(NUM_PLAT);
    localparam int SCROLL_LINE = 200;
    localparam int Y_MAX       = 479;
    localparam int MAX_SCROLL  = 8;
    localparam int SPACING     = 30;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Galois mask for x^16 + x^14 + x^13 + x^11 + 1, right-shifting form.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam logic [8:0] X_MIN  = 9'd48;
    localparam logic [8:0] X_SPAN = 9'd416;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_WAIT,
        ST_SCAN,
        ST_DONE
    } state_e;

    // Folds the low nine LFSR bits into the playable column range 48..463.
    function automatic logic [8:0] rand_x(input logic [15:0] lfsr);
        logic [8:0] r;
        r = lfsr[8:0];
        if (r >= X_SPAN) begin
            r = r - X_SPAN;
        end
        return r + X_MIN;
    endfunction

endpackage

// File: rtl/platform_scheduler_if.sv
// Bundle between the game controller (master) and the platform scheduler (slave).
interface platform_scheduler_if;
    import platform_scheduler_pkg::*;

    logic       frame_tick;
    logic       loadplat;
    logic       run;
    logic [9:0] doodle_y;
    logic       doodle_rising;

    logic [8:0]  plat_x [NUM_PLAT];
    logic [8:0]  plat_y [NUM_PLAT];
    logic [9:0]  scroll_amt;
    logic        frame_done;
    logic        busy;
    logic [15:0] score;
    logic        overrun;

    modport master (
        output frame_tick, loadplat, run, doodle_y, doodle_rising,
        input  plat_x, plat_y, scroll_amt, frame_done, busy, score, overrun
    );

    modport slave (
        input  frame_tick, loadplat, run, doodle_y, doodle_rising,
        output plat_x, plat_y, scroll_amt, frame_done, busy, score, overrun
    );

endinterface

// File: rtl/platform_scheduler_lfsr16.sv
// Free-running 16-bit Galois LFSR feeding the platform X randomiser.
module lfsr16
    import platform_scheduler_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    output logic [15:0] state_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    end

    // NOTE: state registers use <= so every flop samples the values from before the edge.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state_o = lfsr_q;

endmodule

// File: rtl/platform_scheduler.sv
// Platform field scheduler: loads 16 slots, scrolls them once per frame and recycles
// slots that fall off the bottom row with a fresh random X.
module platform_scheduler
    import platform_scheduler_pkg::*;
(
    input logic                 Clk,
    input logic                 Reset,
    platform_scheduler_if.slave bus
);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [9:0]       scroll_q, scroll_d;
    logic [15:0]      score_q, score_d;
    logic             frame_done_q, frame_done_d;
    logic             overrun_q, overrun_d;

    logic [8:0] plat_x_q [NUM_PLAT];
    logic [8:0] plat_y_q [NUM_PLAT];

    logic [15:0] lfsr;
    logic        busy;
    logic        last_slot;
    logic [9:0]  gap;
    logic [9:0]  scroll_calc;
    logic [9:0]  sum;
    logic        wr_y_en;
    logic        wr_x_en;
    logic [8:0]  wr_y;
    logic [8:0]  wr_x;

    lfsr16 u_lfsr (
        .Clk     (Clk),
        .Reset   (Reset),
        .state_o (lfsr)
    );

    assign busy      = (state_q == ST_INIT) || (state_q == ST_SCAN);
    assign last_slot = (idx_q == IDX_W'(NUM_PLAT - 1));
    assign sum       = {1'b0, plat_y_q[idx_q]} + scroll_q;

    // The field only scrolls while the doodle climbs above the scroll line.
    always_comb begin
        gap         = 10'(SCROLL_LINE) - bus.doodle_y;
        scroll_calc = '0;
        if (bus.doodle_rising && (bus.doodle_y < 10'(SCROLL_LINE))) begin
            scroll_calc = (gap > 10'(MAX_SCROLL)) ? 10'(MAX_SCROLL) : gap;
        end
    end

    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        scroll_d     = scroll_q;
        score_d      = score_q;
        overrun_d    = overrun_q;
        frame_done_d = 1'b0;
        wr_y_en      = 1'b0;
        wr_x_en      = 1'b0;
        wr_y         = '0;
        wr_x         = rand_x(lfsr);

        unique case (state_q)
            ST_IDLE: begin
                if (bus.loadplat) state_d = ST_INIT;
            end
            ST_INIT: begin
                wr_y_en = 1'b1;
                wr_x_en = 1'b1;
                wr_y    = 9'(Y_MAX - SPACING * int'(idx_q));
                idx_d   = idx_q + 1'b1;
                if (last_slot) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.loadplat) begin
                    state_d = ST_INIT;
                end else if (bus.frame_tick) begin
                    if (bus.run) begin
                        scroll_d = scroll_calc;
                        state_d  = ST_SCAN;
                    end else begin
                        scroll_d = '0;
                    end
                end
            end
            ST_SCAN: begin
                if (bus.loadplat) begin
                    state_d = ST_INIT;
                end else begin
                    wr_y_en = 1'b1;
                    if (sum > 10'(Y_MAX)) begin
                        wr_y    = 9'(sum - 10'(Y_MAX + 1));
                        wr_x_en = 1'b1;
                        if (score_q != 16'hFFFF) score_d = score_q + 16'd1;
                    end else begin
                        wr_y = sum[8:0];
                    end
                    idx_d = idx_q + 1'b1;
                    if (last_slot) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.loadplat) begin
                    state_d = ST_INIT;
                end else begin
                    frame_done_d = 1'b1;
                    state_d      = ST_WAIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Entering INIT restarts the slot walk and clears the per-load bookkeeping.
        if ((state_d == ST_INIT) && (state_q != ST_INIT)) begin
            idx_d     = '0;
            score_d   = '0;
            overrun_d = 1'b0;
        end else if (bus.frame_tick && busy) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            scroll_q     <= '0;
            score_q      <= '0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            scroll_q     <= scroll_d;
            score_q      <= score_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
        end
    end

    // NOTE: slot storage is plain flops, not a RAM, so it can be cleared by Reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NUM_PLAT; i++) begin
                plat_x_q[i] <= '0;
                plat_y_q[i] <= '0;
            end
        end else begin
            if (wr_y_en) plat_y_q[idx_q] <= wr_y;
            if (wr_x_en) plat_x_q[idx_q] <= wr_x;
        end
    end

    for (genvar g = 0; g < NUM_PLAT; g++) begin : g_slot_out
        assign bus.plat_x[g] = plat_x_q[g];
        assign bus.plat_y[g] = plat_y_q[g];
    end

    assign bus.scroll_amt = scroll_q;
    assign bus.frame_done = frame_done_q;
    assign bus.busy       = busy;
    assign bus.score      = score_q;
    assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_platform_scheduler.sv
// Directed bench for platform_scheduler: load, per-frame scroll table, overrun, abort, reset.
module tb_platform_scheduler;

    typedef struct {
        logic [9:0] dy;
        logic       rising;
        logic       run;
        logic [9:0] exp_scroll;
    } vec_t;

    logic Clk   = 1'b0;
    logic Reset = 1'b1;

    platform_scheduler_if bus ();

    platform_scheduler dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference LFSR and a per-cycle history so expected X values can be rebuilt.
    int          cyc = 0;
    logic [15:0] m_lfsr;
    logic [15:0] hist [0:1023];

    logic [8:0]  exp_x [16];
    logic [8:0]  exp_y [16];
    logic [15:0] exp_score   = '0;
    logic        exp_overrun = 1'b0;

    vec_t vecs [9];

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic [15:0] n;
        logic        b;
        b = s[0];
        n = s >> 1;
        n[15] = n[15] ^ b;
        n[13] = n[13] ^ b;
        n[12] = n[12] ^ b;
        n[10] = n[10] ^ b;
        return n;
    endfunction

    function automatic logic [8:0] rx(input logic [15:0] v);
        logic [8:0] r;
        r = v[8:0];
        return (r >= 9'd416) ? (r - 9'd416 + 9'd48) : (r + 9'd48);
    endfunction

    function automatic logic [8:0] scan_y(input logic [8:0] y, input logic [9:0] a);
        logic [9:0] s;
        s = {1'b0, y} + a;
        return (s > 10'd479) ? 9'(s - 10'd480) : s[8:0];
    endfunction

    always @(posedge Clk) begin
        if (cyc < 1024) hist[cyc] = m_lfsr;
        if (Reset) m_lfsr = 16'hACE1;
        else       m_lfsr = lfsr_step(m_lfsr);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_slots(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            if ((bus.plat_y[i] !== exp_y[i]) || (bus.plat_x[i] !== exp_x[i])) bad++;
        end
        check({tag, "_slots_bad"}, bad, 0);
    endtask

    task automatic set_load_model(input int c0);
        for (int i = 0; i < 16; i++) begin
            exp_y[i] = 9'(479 - 30 * i);
            exp_x[i] = rx(hist[c0 + 1 + i]);
        end
        exp_score   = '0;
        exp_overrun = 1'b0;
    endtask

    // Called at a negedge; pulses loadplat and checks the 16-cycle INIT walk.
    task automatic do_load(input string tag);
        int c0;
        int nbusy;
        bus.loadplat = 1'b1;
        c0 = cyc;
        @(negedge Clk);
        bus.loadplat = 1'b0;
        nbusy = 0;
        repeat (20) begin
            if (bus.busy) nbusy++;
            @(negedge Clk);
        end
        check({tag, "_busy_cycles"}, nbusy, 16);
        set_load_model(c0);
        check_slots(tag);
        check({tag, "_score"}, bus.score, exp_score);
        check({tag, "_overrun"}, bus.overrun, exp_overrun);
    endtask

    // One frame: tick at the current negedge, observe 24 cycles; optional second tick at k.
    task automatic do_frame(input vec_t v, input string tag, input int extra_tick);
        int t0;
        int lat;
        int ndone;
        bus.doodle_y      = v.dy;
        bus.doodle_rising = v.rising;
        bus.run           = v.run;
        bus.frame_tick    = 1'b1;
        t0    = cyc;
        lat   = -1;
        ndone = 0;
        for (int k = 1; k <= 24; k++) begin
            @(negedge Clk);
            bus.frame_tick = (k == extra_tick);
            if (k == 1) check({tag, "_scroll"}, bus.scroll_amt, v.exp_scroll);
            if (bus.frame_done) begin
                ndone++;
                if (lat < 0) lat = k;
            end
        end
        if (extra_tick >= 1 && extra_tick <= 16) exp_overrun = 1'b1;
        check({tag, "_done_pulses"}, ndone, v.run ? 1 : 0);
        if (v.run) begin
            check({tag, "_latency"}, lat, 18);
            for (int i = 0; i < 16; i++) begin
                if (({1'b0, exp_y[i]} + v.exp_scroll) > 10'd479) begin
                    exp_x[i] = rx(hist[t0 + 1 + i]);
                    if (exp_score != 16'hFFFF) exp_score = exp_score + 16'd1;
                end
                exp_y[i] = scan_y(exp_y[i], v.exp_scroll);
            end
        end
        check_slots(tag);
        check({tag, "_score"}, bus.score, exp_score);
        check({tag, "_overrun"}, bus.overrun, exp_overrun);
    endtask

    initial begin
        int t0;
        int nbusy;
        int ndone;
        int nscroll;
        logic [8:0] old_y1;
        logic [8:0] old_y7;
        bool_bad_init: begin end

        bus.frame_tick    = 1'b0;
        bus.loadplat      = 1'b0;
        bus.run           = 1'b0;
        bus.doodle_y      = '0;
        bus.doodle_rising = 1'b0;

        vecs[0] = '{10'd196, 1'b1, 1'b1, 10'd4};
        vecs[1] = '{10'd100, 1'b1, 1'b1, 10'd8};
        vecs[2] = '{10'd250, 1'b1, 1'b1, 10'd0};
        vecs[3] = '{10'd150, 1'b0, 1'b1, 10'd0};
        vecs[4] = '{10'd199, 1'b1, 1'b1, 10'd1};
        vecs[5] = '{10'd200, 1'b1, 1'b1, 10'd0};
        vecs[6] = '{10'd192, 1'b1, 1'b1, 10'd8};
        vecs[7] = '{10'd0,   1'b1, 1'b1, 10'd8};
        vecs[8] = '{10'd100, 1'b1, 1'b0, 10'd0};

        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            exp_x[i] = '0;
            exp_y[i] = '0;
        end
        check_slots("reset");
        check("reset_busy", bus.busy, 0);
        check("reset_scroll", bus.scroll_amt, 0);
        check("reset_score", bus.score, 0);
        check("reset_frame_done", bus.frame_done, 0);
        check("reset_overrun", bus.overrun, 0);

        do_load("load1");
        check("load1_y0", bus.plat_y[0], 479);
        check("load1_y5", bus.plat_y[5], 329);
        check("load1_y15", bus.plat_y[15], 29);
        nbusy = 0;
        for (int i = 0; i < 16; i++) begin
            if (bus.plat_x[i] < 9'd48 || bus.plat_x[i] > 9'd463) nbusy++;
        end
        check("load1_x_out_of_range", nbusy, 0);

        for (int i = 0; i < 9; i++) begin
            do_frame(vecs[i], $sformatf("vec%0d", i), 0);
            if (i == 0) begin
                check("vec0_y15", bus.plat_y[15], 33);
                check("vec0_y0_recycled", bus.plat_y[0], 3);
                check("vec0_score", bus.score, 1);
            end
        end

        do_frame(vecs[0], "overrun", 6);

        // Abort a scan at slot 7 with loadplat.
        old_y1 = exp_y[1];
        old_y7 = exp_y[7];
        bus.doodle_y      = 10'd196;
        bus.doodle_rising = 1'b1;
        bus.run           = 1'b1;
        bus.frame_tick    = 1'b1;
        t0 = cyc;
        for (int k = 1; k <= 30; k++) begin
            @(negedge Clk);
            bus.frame_tick = 1'b0;
            bus.loadplat   = (k == 8);
            if (k == 9) check("abort_busy", bus.busy, 1);
            if (k == 10) begin
                check("abort_y0", bus.plat_y[0], 479);
                check("abort_x0", bus.plat_x[0], rx(hist[t0 + 9]));
                check("abort_score", bus.score, 0);
                check("abort_overrun", bus.overrun, 0);
                check("abort_y1_scanned", bus.plat_y[1], scan_y(old_y1, 10'd4));
                check("abort_y7_untouched", bus.plat_y[7], old_y7);
            end
        end
        set_load_model(t0 + 8);
        check_slots("abort_reload");
        check("abort_idle_busy", bus.busy, 0);

        // Reset in the middle of a scan, with an overrun pending.
        bus.frame_tick = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge Clk);
            bus.frame_tick = (k == 3);
            if (k == 4) check("rst_pre_overrun", bus.overrun, 1);
            Reset = (k == 5);
        end
        for (int i = 0; i < 16; i++) begin
            exp_x[i] = '0;
            exp_y[i] = '0;
        end
        check_slots("rst");
        check("rst_scroll", bus.scroll_amt, 0);
        check("rst_score", bus.score, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_overrun", bus.overrun, 0);
        check("rst_frame_done", bus.frame_done, 0);

        nbusy   = 0;
        ndone   = 0;
        nscroll = 0;
        for (int k = 0; k < 30; k++) begin
            bus.frame_tick = ((k % 5) == 0);
            @(negedge Clk);
            if (bus.busy) nbusy++;
            if (bus.frame_done) ndone++;
            if (bus.scroll_amt != 10'd0) nscroll++;
        end
        bus.frame_tick = 1'b0;
        check("idle_busy_cycles", nbusy, 0);
        check("idle_done_pulses", ndone, 0);
        check("idle_scroll_nonzero", nscroll, 0);
        check_slots("idle");

        do_load("reload");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/platform_scheduler.md
PLATFORM_SCHEDULER -- requirements
Module: platform_scheduler

Interface
REQ-001 Parameters: NUM_PLAT=16 (platform slots); SCROLL_LINE=200 (doodle Y threshold); Y_MAX=479 (bottom row); MAX_SCROLL=8 (px per frame); SPACING=30 (initial Y pitch).
REQ-002 Clk  in  1  system clock; the block's only clock.
REQ-003 Reset  in  1  synchronous, active-high reset; one clock, all state on Clk.
REQ-004 frame_tick  in  1  one-Clk pulse at start of each video frame.
REQ-005 loadplat  in  1  level from game-state FSM; high requests field (re)load.
REQ-006 run  in  1  high while game state is "playing".
REQ-007 doodle_y  in  10  doodle centre Y, unsigned.
REQ-008 doodle_rising  in  1  high when doodle Y motion is negative (moving up).
REQ-009 plat_x[0:15], plat_y[0:15]  out  9 each  platform centre coordinates, registered.
REQ-010 scroll_amt  out  10  px the field moved this frame; held until next frame_tick.
REQ-011 frame_done  out  1  one-Clk pulse when all slots are updated for the frame.
REQ-012 busy  out  1  high in INIT and SCAN.
REQ-013 score  out  16  count of platforms recycled since last load.
REQ-014 overrun  out  1  sticky; set when frame_tick arrives while busy.

Function
REQ-015 FSM states IDLE, INIT, WAIT, SCAN, DONE; busy = (INIT or SCAN).
REQ-016 IDLE -> INIT when loadplat=1; otherwise stay.
REQ-017 INIT: 16 cycles, slot i (0..15) written in cycle i: plat_y[i] = Y_MAX - SPACING*i, plat_x[i] = rand_x; score cleared on INIT entry; -> WAIT after slot 15.
REQ-018 WAIT: on frame_tick with run=1, latch scroll_amt and -> SCAN; frame_tick with run=0 sets scroll_amt=0 and stays in WAIT.
REQ-019 scroll_amt latched = min(SCROLL_LINE - doodle_y, MAX_SCROLL) when doodle_rising=1 and doodle_y < SCROLL_LINE, else 0.
REQ-020 SCAN: 16 cycles, one slot per cycle in index order; s = plat_y[i] + scroll_amt computed in 10 bits.
REQ-021 If s > Y_MAX: plat_y[i] = s - 480, plat_x[i] = rand_x, score += 1 (saturate at 16'hFFFF); else plat_y[i] = s, plat_x unchanged.
REQ-022 SCAN runs all 16 cycles even when scroll_amt=0 (no slot changes, score unchanged).
REQ-023 DONE: frame_done=1 for exactly one cycle, -> WAIT; frame latency tick-to-done = 18 Clk.
REQ-024 rand_x = 48 + (r >= 416 ? r - 416 : r), r = lfsr[8:0]; range 48..463.
REQ-025 lfsr: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1, advances every Clk in every state; never all-zero.
REQ-026 loadplat=1 in WAIT, SCAN or DONE aborts the current operation and -> INIT next cycle; partially scanned slots keep their values until rewritten.
REQ-027 frame_tick while busy: ignored, overrun set; overrun cleared only by Reset or INIT entry.
REQ-028 frame_tick and loadplat in the same cycle: loadplat wins.
REQ-029 plat_x/plat_y change only in INIT or SCAN cycles.

Reset
REQ-030 On Reset: state=IDLE, all plat_x=0, plat_y=0, scroll_amt=0, score=0, frame_done=0, overrun=0, lfsr=16'hACE1.
REQ-031 Reset mid-INIT or mid-SCAN takes effect in the next cycle; no slot write occurs in the Reset cycle.

Structure
REQ-032 Shared package holds the FSM state enum, NUM_PLAT, Y_MAX, SCROLL_LINE, MAX_SCROLL, SPACING, LFSR seed and taps.
REQ-033 One sub-module: lfsr16 (Clk, Reset, 16-bit state out); slot storage and FSM stay in platform_scheduler.

Verification
REQ-034 Reset, loadplat=1 one cycle -> busy 16 cycles; plat_y[0]=479, plat_y[5]=329, plat_y[15]=29; all plat_x in 48..463; score=0.
REQ-035 After load, run=1, doodle_y=196, doodle_rising=1, frame_tick -> scroll_amt=4; frame_done 18 cycles after tick; plat_y[15]=33, plat_y[0]=3 (recycled), plat_x[0] new, score=1.
REQ-036 doodle_y=100, rising=1 -> scroll_amt=8 (clamped); doodle_y=250 or rising=0 -> scroll_amt=0, slots unchanged, frame_done still pulses.
REQ-037 frame_tick 5 cycles into SCAN -> overrun=1, scan completes normally, single frame_done.
REQ-038 loadplat=1 at SCAN slot 7 -> next cycle INIT, slot 0 = 479 two cycles later, score=0, overrun=0.
REQ-039 Reset asserted mid-SCAN -> next cycle all outputs at reset values, state IDLE; frame_tick then ignored until loadplat.
